// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon playback sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simon_pkg;

    localparam int COLOUR_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ON,
        ST_GAP,
        ST_DONE
    } state_t;

    // One-hot LED pattern for a colour index.
    function automatic logic [3:0] colour_to_led(input logic [COLOUR_W-1:0] colour);
        return 4'b0001 << colour;
    endfunction

endpackage

// File: rtl/simon_ms_timer.sv
// Millisecond phase timer: counts whole ms of ticks_per_milli cycles from a clear.
// Latency: expired is registered and high during the last cycle of a target_ms window.
// Backpressure: none; clear restarts the window and resamples tpm/target.
// Ports: clk, rst_n (sync, active-low), ticks_per_milli (0 treated as 1), clear (asserted
//        in the cycle before a phase starts), target_ms (>=1 at clear), expired (1 cycle).
module simon_ms_timer #(
    parameter int MS_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     ticks_per_milli,
    input  logic            clear,
    input  logic [MS_W-1:0] target_ms,
    output logic            expired
);

    logic [15:0]     tpm_q;
    logic [15:0]     tpm_eff;
    logic [15:0]     tick_q;
    logic [15:0]     tick_n;
    logic [MS_W-1:0] ms_q;
    logic [MS_W-1:0] ms_n;
    logic [MS_W-1:0] tgt_q;

    always_comb begin
        tpm_eff = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
        if (tick_q == tpm_q - 16'd1) begin
            tick_n = '0;
            ms_n   = ms_q + MS_W'(1);
        end else begin
            tick_n = tick_q + 16'd1;
            ms_n   = ms_q;
        end
    end

    // expired is computed from the values the counters will hold next cycle, so it is
    // high exactly in the final cycle of the window (including a 1-cycle window).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tpm_q   <= 16'd1;
            tgt_q   <= '0;
            tick_q  <= '0;
            ms_q    <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            tpm_q   <= tpm_eff;
            tgt_q   <= target_ms;
            tick_q  <= '0;
            ms_q    <= '0;
            expired <= (tpm_eff == 16'd1) && (target_ms == MS_W'(1));
        end else begin
            tick_q  <= tick_n;
            ms_q    <= ms_n;
            expired <= (tick_n == tpm_q - 16'd1) && (ms_n == tgt_q - MS_W'(1));
        end
    end

endmodule

// File: rtl/simon_playback_seq.sv
// Simon "show" sequencer: fetches colours from RAM, lights LED + tone per step, then gaps.
// Latency: start -> mem_rd next cycle, first LED 3 cycles after start; 2-cycle fetch per step.
// Backpressure: none; start ignored while busy, abort returns to idle next cycle, no done.
// Ports: clk, rst_n (sync, active-low), ticks_per_milli, start, abort, seq_len, step_ms, gap_ms,
//        mem_rd/mem_addr/mem_data (read port, data one cycle after strobe), led, tone_en,
//        tone_sel, busy, done.
// Option: define SIMON_PLAYBACK_SPEEDUP_EN to shorten on-time for long sequences.
module simon_playback_seq
    import simon_pkg::*;
#(
    parameter  int MAX_LEN = 32,
    parameter  int MS_W    = 10,
    localparam int ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         ticks_per_milli,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W:0]     seq_len,
    input  logic [MS_W-1:0]     step_ms,
    input  logic [MS_W-1:0]     gap_ms,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [COLOUR_W-1:0] mem_data,
    output logic [3:0]          led,
    output logic                tone_en,
    output logic [COLOUR_W-1:0] tone_sel,
    output logic                busy,
    output logic                done
);

    localparam int LEN_W = ADDR_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] step_q;
    logic [ADDR_W-1:0] next_step;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_clamp;
    logic [MS_W-1:0]   step_eff;
    logic [MS_W-1:0]   on_ms;
    logic              last_step;
    logic              tmr_clear;
    logic [MS_W-1:0]   tmr_target;
    logic              tmr_expired;

    assign len_clamp = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;
    assign next_step = step_q + ADDR_W'(1);
    assign last_step = ({1'b0, step_q} == len_q - LEN_W'(1));

    always_comb begin
        step_eff = (step_ms == '0) ? MS_W'(1) : step_ms;
        on_ms    = step_eff;
`ifdef SIMON_PLAYBACK_SPEEDUP_EN
        if (len_q >= LEN_W'(14)) begin
            on_ms = step_eff >> 1;
        end else if (len_q >= LEN_W'(6)) begin
            on_ms = step_eff - (step_eff >> 2);
        end
        if (on_ms == '0) begin
            on_ms = MS_W'(1);
        end
`endif
    end

    // The timer is cleared in the cycle before a timed phase begins so that its
    // registered expired lands on the phase's final cycle.
    assign tmr_clear  = (state == ST_WAIT) ||
                        ((state == ST_ON) && tmr_expired && !last_step && (gap_ms != '0));
    assign tmr_target = (state == ST_WAIT) ? on_ms : gap_ms;

    simon_ms_timer #(.MS_W(MS_W)) u_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (ticks_per_milli),
        .clear           (tmr_clear),
        .target_ms       (tmr_target),
        .expired         (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state    <= ST_IDLE;
            step_q   <= '0;
            len_q    <= '0;
            led      <= '0;
            tone_en  <= 1'b0;
            tone_sel <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= len_clamp;
                        if (len_clamp == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_FETCH;
                            step_q   <= '0;
                            mem_rd   <= 1'b1;
                            mem_addr <= '0;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    tone_sel <= mem_data;
                    led      <= colour_to_led(mem_data);
                    tone_en  <= 1'b1;
                    state    <= ST_ON;
                end
                ST_ON: begin
                    if (tmr_expired) begin
                        led     <= '0;
                        tone_en <= 1'b0;
                        if (last_step) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (gap_ms != '0) begin
                            state <= ST_GAP;
                        end else begin
                            state    <= ST_FETCH;
                            step_q   <= next_step;
                            mem_rd   <= 1'b1;
                            mem_addr <= next_step;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_expired) begin
                        state    <= ST_FETCH;
                        step_q   <= next_step;
                        mem_rd   <= 1'b1;
                        mem_addr <= next_step;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_playback_seq.sv
// Bench for simon_playback_seq: per-cycle comparison against a timeline model plus pinned cases.
module tb_simon_playback_seq;

    typedef struct packed {
        logic [3:0] led;
        logic       tone_en;
        logic [1:0] tone_sel;
        logic       mem_rd;
        logic [4:0] mem_addr;
        logic       busy;
        logic       done;
    } obs_t;

    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ticks_per_milli;
    logic        start;
    logic        abort;
    logic [5:0]  seq_len;
    logic [9:0]  step_ms;
    logic [9:0]  gap_ms;
    logic        mem_rd;
    logic [4:0]  mem_addr;
    logic [1:0]  mem_data = 2'd0;
    logic [3:0]  led;
    logic        tone_en;
    logic [1:0]  tone_sel;
    logic        busy;
    logic        done;

    logic [1:0]  mem_arr [32];
    obs_t        q [$];
    logic [1:0]  model_sel = 2'd0;
    bit          chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    simon_playback_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (ticks_per_milli),
        .start           (start),
        .abort           (abort),
        .seq_len         (seq_len),
        .step_ms         (step_ms),
        .gap_ms          (gap_ms),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .led             (led),
        .tone_en         (tone_en),
        .tone_sel        (tone_sel),
        .busy            (busy),
        .done            (done)
    );

    // External RAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_arr[mem_addr];
    end

    function automatic int eff_on(input int s, input int len);
        int v;
        v = (s == 0) ? 1 : s;
`ifdef SIMON_PLAYBACK_SPEEDUP_EN
        if (len >= 14)     v = v / 2;
        else if (len >= 6) v = v - v / 4;
        if (v < 1) v = 1;
`endif
        return v;
    endfunction

    // Expected outputs for every cycle of a playback, starting the cycle after start.
    function automatic void build();
        int   len, t, on, gp;
        logic [1:0] sel, c;
        obs_t e;
        len = (int'(seq_len) > 32) ? 32 : int'(seq_len);
        t   = (ticks_per_milli == 16'd0) ? 1 : int'(ticks_per_milli);
        on  = eff_on(int'(step_ms), len);
        gp  = int'(gap_ms);
        sel = model_sel;
        for (int i = 0; i < len; i++) begin
            e = '0; e.tone_sel = sel; e.busy = 1'b1;
            e.mem_rd = 1'b1; e.mem_addr = 5'(i);
            q.push_back(e);
            e.mem_rd = 1'b0; e.mem_addr = 5'd0;
            q.push_back(e);
            c = mem_arr[i];
            sel = c;
            e.tone_sel = c; e.led = 4'(1 << c); e.tone_en = 1'b1;
            for (int k = 0; k < on * t; k++) q.push_back(e);
            e.led = 4'd0; e.tone_en = 1'b0;
            if (i < len - 1) begin
                for (int k = 0; k < gp * t; k++) q.push_back(e);
            end
        end
        e = '0; e.tone_sel = sel; e.done = 1'b1;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        obs_t exp_v, act_v;
        bit   idle;
        if (chk_en) begin
            idle = (q.size() == 0);
            if (idle) begin
                exp_v = '0;
                exp_v.tone_sel = model_sel;
            end else begin
                exp_v = q.pop_front();
            end
            act_v.led = led; act_v.tone_en = tone_en; act_v.tone_sel = tone_sel;
            act_v.mem_rd = mem_rd; act_v.mem_addr = exp_v.mem_rd ? mem_addr : 5'd0;
            act_v.busy = busy; act_v.done = done;
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle t=%0t got led=%b ten=%b sel=%0d rd=%b addr=%0d busy=%b done=%b want led=%b ten=%b sel=%0d rd=%b addr=%0d busy=%b done=%b",
                    $time, act_v.led, act_v.tone_en, act_v.tone_sel, act_v.mem_rd, act_v.mem_addr,
                    act_v.busy, act_v.done, exp_v.led, exp_v.tone_en, exp_v.tone_sel,
                    exp_v.mem_rd, exp_v.mem_addr, exp_v.busy, exp_v.done);
            end
            model_sel = exp_v.tone_sel;
            if (abort) begin
                q.delete();
                model_sel = 2'd0;
            end else if (idle && start) begin
                build();
            end
        end
    end

    task automatic pin(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic run_play(input int len, input int st, input int gp, input int tp,
                            input int ab_at, input bit noise, input bit pin1,
                            output int n_rd, output int n_on, output int done_rel);
        int cnt, rel;
        seq_len = 6'(len); step_ms = 10'(st); gap_ms = 10'(gp);
        ticks_per_milli = 16'(tp);
        start = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0; n_rd = 0; n_on = 0; done_rel = -1;
        if (pin1) pin("t1_model_len", q.size(), 39);
        while (q.size() != 0 && cnt < LIMIT) begin
            rel = cnt + 1;
            if (mem_rd) n_rd++;
            if (led != 4'd0) n_on++;
            if (done && done_rel < 0) done_rel = rel;
            if (pin1) begin
                case (rel)
                    1:  pin("t1_addr0", mem_rd ? int'(mem_addr) : -1, 0);
                    15: pin("t1_addr1", mem_rd ? int'(mem_addr) : -1, 1);
                    29: pin("t1_addr2", mem_rd ? int'(mem_addr) : -1, 2);
                    3, 10:          pin("t1_led_red", int'(led), 4);
                    11, 14, 25, 28: pin("t1_led_gap", int'(led), 0);
                    17, 24:         pin("t1_led_s1", int'(led), 1);
                    31:             pin("t1_led_s2", int'(led), 8);
                    38: begin
                        pin("t1_led_s2_end", int'(led), 8);
                        pin("t1_done_early", int'(done), 0);
                    end
                    default: ;
                endcase
            end
            start = noise && ($urandom_range(0, 3) == 0);
            abort = (rel == ab_at);
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0; abort = 1'b0;
        if (cnt >= LIMIT) pin("timeout", cnt, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_t1();
        mem_arr[0] = 2'd2; mem_arr[1] = 2'd0; mem_arr[2] = 2'd3;
    endtask

    initial begin
        int n_rd, n_on, d_rel, len, ab;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        seq_len = '0; step_ms = '0; gap_ms = '0; ticks_per_milli = '0;
        for (int i = 0; i < 32; i++) mem_arr[i] = 2'(i);
        repeat (3) @(posedge clk);
        #1;
        pin("rst_led", int'(led), 0);
        pin("rst_busy", int'(busy), 0);
        pin("rst_rd", int'(mem_rd), 0);
        pin("rst_done", int'(done), 0);
        pin("rst_sel", int'(tone_sel), 0);
        pin("rst_addr", int'(mem_addr), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Reference run with literal timing.
        load_t1();
        run_play(3, 2, 1, 4, -1, 1'b0, 1'b1, n_rd, n_on, d_rel);
        pin("t1_done_cycle", d_rel, 39);
        pin("t1_reads", n_rd, 3);
        pin("t1_on_cycles", n_on, 24);

        // No gap: steps separated only by the 2-cycle fetch.
        run_play(2, 2, 0, 1, -1, 1'b0, 1'b0, n_rd, n_on, d_rel);
        pin("t2_done_cycle", d_rel, 9);
        pin("t2_on_cycles", n_on, 4);

        // Abort during the second ON phase, then restart.
        load_t1();
        run_play(3, 2, 1, 4, 20, 1'b0, 1'b0, n_rd, n_on, d_rel);
        pin("t3_no_done", d_rel, -1);
        pin("t3_busy_after", int'(busy), 0);
        load_t1();
        run_play(3, 2, 1, 4, -1, 1'b0, 1'b1, n_rd, n_on, d_rel);
        pin("t3_restart_done", d_rel, 39);

        // Empty sequence and over-long sequence.
        run_play(0, 3, 1, 2, -1, 1'b0, 1'b0, n_rd, n_on, d_rel);
        pin("t4_len0_done", d_rel, 1);
        pin("t4_len0_reads", n_rd, 0);
        run_play(40, 1, 0, 1, -1, 1'b0, 1'b0, n_rd, n_on, d_rel);
        pin("t4_len40_reads", n_rd, 32);

        // start together with abort in idle is ignored.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        pin("t5_start_abort_busy", int'(busy), 0);
        @(posedge clk); #1;
        pin("t5_start_abort_rd", int'(mem_rd), 0);

        // On-time scaling with sequence length.
        for (int i = 0; i < 32; i++) mem_arr[i] = 2'($urandom_range(0, 3));
        run_play(14, 8, 0, 1, -1, 1'b0, 1'b0, n_rd, n_on, d_rel);
`ifdef SIMON_PLAYBACK_SPEEDUP_EN
        pin("t6_len14_on", n_on, 56);
`else
        pin("t6_len14_on", n_on, 112);
`endif
        run_play(6, 8, 0, 1, -1, 1'b0, 1'b0, n_rd, n_on, d_rel);
`ifdef SIMON_PLAYBACK_SPEEDUP_EN
        pin("t6_len6_on", n_on, 36);
`else
        pin("t6_len6_on", n_on, 48);
`endif
        run_play(5, 8, 0, 1, -1, 1'b0, 1'b0, n_rd, n_on, d_rel);
        pin("t6_len5_on", n_on, 40);

        // Randomised runs with start noise while busy and occasional aborts.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 32; i++) mem_arr[i] = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(1, 16));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1;
            run_play(len, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), ab, 1'b1, 1'b0, n_rd, n_on, d_rel);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
